alu_control_seq: RTL and testbench

//  Next-gen ALU control. Decodes {alu_op, funct} to the 4-bit ALU operation code (same cycle).

---
 rtl/alu_ctrl_pkg.sv | 57 +++++
 rtl/alu_control_seq_md_sequencer.sv | 73 +++++++
 rtl/alu_control_seq.sv | 84 ++++++++
 tb/tb_alu_control_seq.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/alu_ctrl_pkg.sv
// Shared codes for the ALU control slice: alu_op classes, R-type funct values,
// ALU operation codes, mult/div op encoding and sequencer states.
package alu_ctrl_pkg;

  // alu_op classes from main Control
  localparam logic [2:0] ALU_OP_LUI   = 3'b000;
  localparam logic [2:0] ALU_OP_ORI   = 3'b001;
  localparam logic [2:0] ALU_OP_ANDI  = 3'b010;
  localparam logic [2:0] ALU_OP_SLTI  = 3'b011;
  localparam logic [2:0] ALU_OP_ADDI  = 3'b100;
  localparam logic [2:0] ALU_OP_LDST  = 3'b101;
  localparam logic [2:0] ALU_OP_BR    = 3'b110;
  localparam logic [2:0] ALU_OP_RTYPE = 3'b111;

  // R-type funct field
  localparam logic [5:0] FUNCT_SLL   = 6'b000000;
  localparam logic [5:0] FUNCT_SRL   = 6'b000010;
  localparam logic [5:0] FUNCT_MULT  = 6'b011000;
  localparam logic [5:0] FUNCT_MULTU = 6'b011001;
  localparam logic [5:0] FUNCT_DIV   = 6'b011010;
  localparam logic [5:0] FUNCT_DIVU  = 6'b011011;
  localparam logic [5:0] FUNCT_ADD   = 6'b100000;
  localparam logic [5:0] FUNCT_SUB   = 6'b100010;
  localparam logic [5:0] FUNCT_AND   = 6'b100100;
  localparam logic [5:0] FUNCT_OR    = 6'b100101;
  localparam logic [5:0] FUNCT_NOR   = 6'b100111;
  localparam logic [5:0] FUNCT_SLT   = 6'b101010;

  // ALU operation codes
  localparam logic [3:0] ALU_OPER_LUI     = 4'b0000;
  localparam logic [3:0] ALU_OPER_OR      = 4'b0001;
  localparam logic [3:0] ALU_OPER_SLL     = 4'b0010;
  localparam logic [3:0] ALU_OPER_ADD     = 4'b0011;
  localparam logic [3:0] ALU_OPER_SRL     = 4'b0100;
  localparam logic [3:0] ALU_OPER_SUB     = 4'b0101;
  localparam logic [3:0] ALU_OPER_AND     = 4'b0110;
  localparam logic [3:0] ALU_OPER_MULT    = 4'b0111;
  localparam logic [3:0] ALU_OPER_DIV     = 4'b1000;
  localparam logic [3:0] ALU_OPER_ILLEGAL = 4'b1001;
  localparam logic [3:0] ALU_OPER_SLT     = 4'b1010;
  localparam logic [3:0] ALU_OPER_NOR     = 4'b1011;

  // Mult/div op; matches funct[1:0] of the MD instructions
  typedef enum logic [1:0] {
    MD_MULT  = 2'b00,
    MD_MULTU = 2'b01,
    MD_DIV   = 2'b10,
    MD_DIVU  = 2'b11
  } md_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_BUSY = 2'b01,
    ST_DONE = 2'b10
  } md_state_e;

endpackage

// File: rtl/alu_control_seq_md_sequencer.sv
// Mult/div sequencer: start pulse on accept, stall while the iterative datapath
// runs, one HI/LO write strobe on the cycle the held instruction retires.
module md_sequencer
  import alu_ctrl_pkg::*;
#(
  parameter int MD_CYCLES = 32
) (
  input  logic   clk,
  input  logic   reset,
  input  logic   start_req,
  input  md_op_e md_op,
  output logic   start,
  output logic   stall,
  output logic   hilo_we,
  output md_op_e md_op_o
);

  localparam int CNT_W = $clog2(MD_CYCLES);

  md_state_e        state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;

  // State, counter and latched op; reset wins over any acceptance
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      md_op_o <= MD_MULT;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      if (start) md_op_o <= md_op;
    end
  end

  // Next state and strobes. BUSY lasts MD_CYCLES-1 cycles so that the accept
  // cycle plus BUSY gives exactly MD_CYCLES stalled cycles; cnt lands on 0
  // as DONE is entered.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    start    = 1'b0;
    stall    = 1'b0;
    hilo_we  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start_req) begin
          start    = 1'b1;
          stall    = 1'b1;
          cnt_nx   = CNT_W'(MD_CYCLES - 1);
          state_nx = ST_BUSY;
        end
      end
      ST_BUSY: begin
        stall  = 1'b1;
        cnt_nx = cnt - CNT_W'(1);
        if (cnt == CNT_W'(1)) state_nx = ST_DONE;
      end
      ST_DONE: begin
        hilo_we  = 1'b1;
        state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
    // Strobes are silenced in a reset cycle so an aborted op leaves no trace
    if (reset) begin
      start   = 1'b0;
      stall   = 1'b0;
      hilo_we = 1'b0;
    end
  end

endmodule

// File: rtl/alu_control_seq.sv
// ALU control: zero-latency {alu_op, funct} decode plus mult/div sequencing.
// Define ALU_CTRL_DIV_EN to decode and sequence DIV/DIVU; otherwise they are illegal.
module alu_control_seq
  import alu_ctrl_pkg::*;
#(
  parameter int ALU_OP_W  = 3,
  parameter int FUNCT_W   = 6,
  parameter int OPER_W    = 4,
  parameter int MD_CYCLES = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                valid_i,
  input  logic [ALU_OP_W-1:0] alu_op_i,
  input  logic [FUNCT_W-1:0]  alu_function_i,
  output logic [OPER_W-1:0]   alu_operation_o,
  output logic                illegal_o,
  output logic                md_start_o,
  output logic [1:0]          md_op_o,
  output logic                stall_o,
  output logic                hilo_we_o
);

  logic   match;
  logic   md_req;
  md_op_e md_op_q;

  // Combinational decode; unmatched selectors fall through to the illegal code
  always_comb begin
    alu_operation_o = ALU_OPER_ILLEGAL;
    match           = 1'b1;
    md_req          = 1'b0;
    case (alu_op_i)
      ALU_OP_LUI:  alu_operation_o = ALU_OPER_LUI;
      ALU_OP_ORI:  alu_operation_o = ALU_OPER_OR;
      ALU_OP_ANDI: alu_operation_o = ALU_OPER_AND;
      ALU_OP_SLTI: alu_operation_o = ALU_OPER_SLT;
      ALU_OP_ADDI: alu_operation_o = ALU_OPER_ADD;
      ALU_OP_LDST: alu_operation_o = ALU_OPER_ADD;
      ALU_OP_BR:   alu_operation_o = ALU_OPER_SUB;
      ALU_OP_RTYPE: begin
        case (alu_function_i)
          FUNCT_ADD: alu_operation_o = ALU_OPER_ADD;
          FUNCT_SUB: alu_operation_o = ALU_OPER_SUB;
          FUNCT_AND: alu_operation_o = ALU_OPER_AND;
          FUNCT_OR:  alu_operation_o = ALU_OPER_OR;
          FUNCT_NOR: alu_operation_o = ALU_OPER_NOR;
          FUNCT_SLT: alu_operation_o = ALU_OPER_SLT;
          FUNCT_SLL: alu_operation_o = ALU_OPER_SLL;
          FUNCT_SRL: alu_operation_o = ALU_OPER_SRL;
          FUNCT_MULT, FUNCT_MULTU: begin
            alu_operation_o = ALU_OPER_MULT;
            md_req          = 1'b1;
          end
`ifdef ALU_CTRL_DIV_EN
          FUNCT_DIV, FUNCT_DIVU: begin
            alu_operation_o = ALU_OPER_DIV;
            md_req          = 1'b1;
          end
`endif
          default: match = 1'b0;
        endcase
      end
      default: match = 1'b0;
    endcase
  end

  assign illegal_o = valid_i & ~match;
  assign md_op_o   = md_op_q;

  md_sequencer #(
    .MD_CYCLES (MD_CYCLES)
  ) u_md_seq (
    .clk       (clk),
    .reset     (reset),
    .start_req (valid_i & md_req),
    .md_op     (md_op_e'(alu_function_i[1:0])),
    .start     (md_start_o),
    .stall     (stall_o),
    .hilo_we   (hilo_we_o),
    .md_op_o   (md_op_q)
  );

endmodule

// File: tb/tb_alu_control_seq.sv
// Bench for alu_control_seq (MD_CYCLES=4): a cycle-timeline model checked on
// every falling edge, plus directed vectors with literal expectations.
module tb_alu_control_seq;

  localparam int N = 4;

  logic       clk = 1'b0;
  logic       reset, valid_i;
  logic [2:0] alu_op_i;
  logic [5:0] fn;
  logic [3:0] alu_operation_o;
  logic       illegal_o, md_start_o, stall_o, hilo_we_o;
  logic [1:0] md_op_o;

  alu_control_seq #(
    .ALU_OP_W (3), .FUNCT_W (6), .OPER_W (4), .MD_CYCLES (N)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .valid_i         (valid_i),
    .alu_op_i        (alu_op_i),
    .alu_function_i  (fn),
    .alu_operation_o (alu_operation_o),
    .illegal_o       (illegal_o),
    .md_start_o      (md_start_o),
    .md_op_o         (md_op_o),
    .stall_o         (stall_o),
    .hilo_we_o       (hilo_we_o)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  // Reference decode straight from the opcode tables (decimal funct values)
  function automatic void ref_dec(input logic [2:0] op, input logic [5:0] f,
                                  output int oper, output bit md);
    bit div_en;
`ifdef ALU_CTRL_DIV_EN
    div_en = 1'b1;
`else
    div_en = 1'b0;
`endif
    md = 1'b0;
    case (op)
      3'd0: oper = 0;
      3'd1: oper = 1;
      3'd2: oper = 6;
      3'd3: oper = 10;
      3'd4: oper = 3;
      3'd5: oper = 3;
      3'd6: oper = 5;
      default: begin
        case (int'(f))
          32: oper = 3;
          34: oper = 5;
          36: oper = 6;
          37: oper = 1;
          39: oper = 11;
          42: oper = 10;
          0:  oper = 2;
          2:  oper = 4;
          24, 25: begin oper = 7; md = 1'b1; end
          26, 27: begin
            if (div_en) begin oper = 8; md = 1'b1; end
            else oper = 9;
          end
          default: oper = 9;
        endcase
      end
    endcase
  endfunction

  // Timeline model: 'since' = cycles elapsed since an accepted MD op (-1 idle)
  int cyc = 0;
  int since = -1;
  int m_op = 0;
  int n_start = 0;
  int last_start = -1;
  int last_hilo = -1;

  always @(posedge clk) cyc <= cyc + 1;

  // Compare DUT against the model every cycle, then advance the model
  always @(negedge clk) begin
    int  eo;
    bit  md, acc;
    ref_dec(alu_op_i, fn, eo, md);
    chk("oper", int'(alu_operation_o), eo);
    chk("illegal", int'(illegal_o), int'(valid_i && eo == 9));
    if (!reset) begin
      acc = (since < 0) && valid_i && md;
      chk("start", int'(md_start_o), int'(acc));
      chk("stall", int'(stall_o), int'(acc || (since > 0 && since < N)));
      chk("hilo_we", int'(hilo_we_o), int'(since == N));
      chk("md_op", int'(md_op_o), m_op);
      if (md_start_o) begin n_start++; last_start = cyc; end
      if (hilo_we_o) last_hilo = cyc;
      if (acc) begin since = 1; m_op = int'(fn[1:0]); end
      else if (since > 0 && since < N) since = since + 1;
      else since = -1;
    end else begin
      since = -1;
      m_op  = 0;
    end
  end

  // Drive one cycle of inputs just after the rising edge, settle before checks
  task automatic drv(input logic v, input logic [2:0] op, input logic [5:0] f);
    @(posedge clk);
    #1;
    valid_i  = v;
    alu_op_i = op;
    fn       = f;
    #2;
  endtask

  initial begin
    logic [5:0] fmd;
    int s0;
    reset = 1'b1; valid_i = 1'b0; alu_op_i = 3'd0; fn = 6'd0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    #2;
    chk("rst_stall", int'(stall_o), 0);
    chk("rst_hilo", int'(hilo_we_o), 0);
    chk("rst_md_op", int'(md_op_o), 0);

    // Plain decode
    drv(1, 3'b111, 6'b100000); chk("add", int'(alu_operation_o), 4'b0011);
    chk("add_stall", int'(stall_o), 0);
    drv(1, 3'b111, 6'b101010); chk("slt", int'(alu_operation_o), 4'b1010);
    drv(1, 3'b111, 6'b100111); chk("nor", int'(alu_operation_o), 4'b1011);
    chk("nor_stall", int'(stall_o), 0);
    drv(1, 3'b100, 6'b110101); chk("addi", int'(alu_operation_o), 4'b0011);
    drv(1, 3'b000, 6'b001100); chk("lui", int'(alu_operation_o), 4'b0000);
    drv(1, 3'b111, 6'b111111); chk("ill_op", int'(alu_operation_o), 4'b1001);
    chk("ill_flag", int'(illegal_o), 1);
    drv(0, 3'b111, 6'b111111); chk("ill_noval", int'(illegal_o), 0);

    // MULT held on the inputs for the whole sequence
    s0 = n_start;
    drv(1, 3'b111, 6'b011000);
    chk("mult_oper", int'(alu_operation_o), 4'b0111);
    chk("mult_start_T", int'(md_start_o), 1);
    chk("mult_stall_T", int'(stall_o), 1);
    drv(1, 3'b111, 6'b011000);
    chk("mult_start_T1", int'(md_start_o), 0);
    chk("mult_md_op", int'(md_op_o), 0);
    drv(1, 3'b111, 6'b011000);
    drv(1, 3'b111, 6'b011000);
    chk("mult_stall_T3", int'(stall_o), 1);
    drv(1, 3'b111, 6'b011000);
    chk("mult_stall_T4", int'(stall_o), 0);
    chk("mult_hilo_T4", int'(hilo_we_o), 1);
    drv(0, 3'b111, 6'b000000);
    chk("mult_hilo_T5", int'(hilo_we_o), 0);
    chk("mult_one_start", n_start - s0, 1);
    chk("mult_hilo_lat", last_hilo - last_start, N);

    // MFLO in IDLE
    drv(1, 3'b111, 6'b010010);
    chk("mflo_stall", int'(stall_o), 0);
    chk("mflo_hilo", int'(hilo_we_o), 0);
    drv(0, 3'b000, 6'b000000);

    // Reset in the middle of a long op, then a clean restart
`ifdef ALU_CTRL_DIV_EN
    fmd = 6'b011011;
`else
    fmd = 6'b011001;
`endif
    drv(1, 3'b111, fmd);
    chk("abort_start", int'(md_start_o), 1);
    drv(1, 3'b111, fmd);
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0; valid_i = 1'b0;
    #2;
    chk("abort_stall", int'(stall_o), 0);
    chk("abort_start0", int'(md_start_o), 0);
    chk("abort_hilo", int'(hilo_we_o), 0);
    chk("abort_md_op", int'(md_op_o), 0);
    s0 = last_hilo;
    repeat (5) drv(0, 3'b000, 6'b000000);
    chk("abort_no_hilo", last_hilo, s0);

    drv(1, 3'b111, fmd);
    chk("restart_start", int'(md_start_o), 1);
    drv(1, 3'b111, fmd);
    chk("restart_md_op", int'(md_op_o), int'(fmd[1:0]));
    drv(1, 3'b111, fmd);
    drv(1, 3'b111, fmd);
    chk("restart_stall_T3", int'(stall_o), 1);
    drv(1, 3'b111, fmd);
    chk("restart_hilo_T4", int'(hilo_we_o), 1);
    drv(0, 3'b000, 6'b000000);
    chk("restart_hilo_lat", last_hilo - last_start, N);

    // Reset beats acceptance in the same cycle
    @(posedge clk); #1 reset = 1'b1; valid_i = 1'b1; alu_op_i = 3'b111; fn = 6'b011000;
    @(posedge clk); #1 reset = 1'b0; valid_i = 1'b0;
    #2;
    chk("rstprio_stall", int'(stall_o), 0);
    drv(0, 3'b000, 6'b000000);
    chk("rstprio_stall2", int'(stall_o), 0);

    // DIV under the current build configuration
    drv(1, 3'b111, 6'b011010);
`ifdef ALU_CTRL_DIV_EN
    chk("div_oper", int'(alu_operation_o), 4'b1000);
    chk("div_start", int'(md_start_o), 1);
    repeat (4) drv(1, 3'b111, 6'b011010);
    chk("div_hilo", int'(hilo_we_o), 1);
`else
    chk("div_oper", int'(alu_operation_o), 4'b1001);
    chk("div_illegal", int'(illegal_o), 1);
    chk("div_start", int'(md_start_o), 0);
    chk("div_stall", int'(stall_o), 0);
`endif
    repeat (3) drv(0, 3'b000, 6'b000000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
